// File: rtl/cache_pkg.sv
// Shared types and constants for the cache controller and its helpers.
package cache_pkg;

  localparam int DEFAULT_ADDRESS_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH    = 32;
  // Byte-offset bits inside one word; these are zeroed toward memory.
  localparam int OFFSET_SIZE           = $clog2(DEFAULT_DATA_WIDTH / 8);
  localparam int STAT_WIDTH            = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_READ,
    MEM_WRITE,
    DONE
  } cache_state_e;

endpackage

// File: rtl/cache_stat_counter.sv
// Saturating event counter: counts inc_i pulses and sticks at all-ones.
module cache_stat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_reg;

  // Increment on each event unless the counter is already saturated.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_reg <= '0;
    end else if (inc_i && (count_reg != {WIDTH{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count_o = count_reg;

endmodule

// File: rtl/cache_controller.sv
// Cache controller: sequences one CPU load/store at a time through tag
// lookup, read-miss refill and write-through (no write-allocate) against a
// direct-mapped cache array and a single-word memory port.
// Optional feature macro: CACHE_STATS_EN adds read hit/miss counters.
module cache_controller
  import cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cpu_req_i,
  input  logic                     cpu_we_i,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata_i,
  output logic [DATA_WIDTH-1:0]    cpu_rdata_o,
  output logic                     cpu_ready_o,
  output logic [ADDRESS_WIDTH-1:0] cache_addr_o,
  input  logic                     cache_hit_i,
  input  logic [DATA_WIDTH-1:0]    cache_rdata_i,
  output logic                     cache_we_o,
  output logic [DATA_WIDTH-1:0]    cache_wdata_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]    mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
  input  logic                     mem_ack_i
`ifdef CACHE_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]    hit_count_o,
  output logic [STAT_WIDTH-1:0]    miss_count_o
`endif
);

  // Offset width follows the actual word width so non-default builds align correctly.
  localparam int OFFSET_BITS = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK =
    ~ADDRESS_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

  cache_state_e             state_reg;
  logic [ADDRESS_WIDTH-1:0] addr_reg;
  logic                     we_reg;
  logic [DATA_WIDTH-1:0]    wdata_reg;
  logic [DATA_WIDTH-1:0]    cpu_rdata_reg;
  logic                     cpu_ready_reg;
  logic                     mem_req_reg;
  logic                     mem_we_reg;
  logic [ADDRESS_WIDTH-1:0] mem_addr_reg;
  logic [DATA_WIDTH-1:0]    mem_wdata_reg;

  // Main sequencer: latches the request and drives every registered output.
  // Memory-side outputs only change on entry to or exit from a MEM state,
  // so they stay stable for the whole handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      we_reg        <= 1'b0;
      wdata_reg     <= '0;
      cpu_rdata_reg <= '0;
      cpu_ready_reg <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cpu_req_i) begin
            addr_reg  <= cpu_addr_i;
            we_reg    <= cpu_we_i;
            wdata_reg <= cpu_wdata_i;
            state_reg <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (we_reg) begin
            // Write-through: memory is always updated, hit or miss.
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= 1'b1;
            mem_addr_reg  <= addr_reg & ALIGN_MASK;
            mem_wdata_reg <= wdata_reg;
            state_reg     <= MEM_WRITE;
          end else if (cache_hit_i) begin
            cpu_rdata_reg <= cache_rdata_i;
            cpu_ready_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= addr_reg & ALIGN_MASK;
            mem_wdata_reg <= '0;
            state_reg     <= MEM_READ;
          end
        end

        MEM_READ: begin
          if (mem_ack_i) begin
            mem_req_reg   <= 1'b0;
            cpu_rdata_reg <= mem_rdata_i;
            cpu_ready_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end

        MEM_WRITE: begin
          if (mem_ack_i) begin
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            cpu_rdata_reg <= '0;
            cpu_ready_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end

        DONE: begin
          // Completion lasts exactly one cycle; any new request waits for IDLE.
          cpu_ready_reg <= 1'b0;
          cpu_rdata_reg <= '0;
          state_reg     <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Cache write port: must fire in the same cycle as the hit/ack it depends
  // on, so it is decoded from the current state and live inputs.
  always_comb begin
    cache_we_o    = 1'b0;
    cache_wdata_o = '0;
    case (state_reg)
      LOOKUP: begin
        if (we_reg && cache_hit_i) begin
          cache_we_o    = 1'b1;
          cache_wdata_o = wdata_reg;
        end
      end
      MEM_READ: begin
        if (mem_ack_i) begin
          cache_we_o    = 1'b1;
          cache_wdata_o = mem_rdata_i;
        end
      end
      default: begin
        cache_we_o    = 1'b0;
        cache_wdata_o = '0;
      end
    endcase
  end

  assign cpu_rdata_o  = cpu_rdata_reg;
  assign cpu_ready_o  = cpu_ready_reg;
  assign cache_addr_o = addr_reg;
  assign mem_req_o    = mem_req_reg;
  assign mem_we_o     = mem_we_reg;
  assign mem_addr_o   = mem_addr_reg;
  assign mem_wdata_o  = mem_wdata_reg;

`ifdef CACHE_STATS_EN
  // Read-only statistics: index 0 counts hits, index 1 counts misses.
  logic [1:0]            stat_inc;
  logic [STAT_WIDTH-1:0] stat_count [2];

  assign stat_inc[0] = (state_reg == LOOKUP) && !we_reg &&  cache_hit_i;
  assign stat_inc[1] = (state_reg == LOOKUP) && !we_reg && !cache_hit_i;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
      cache_stat_counter #(
        .WIDTH (STAT_WIDTH)
      ) u_stat_counter (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (stat_inc[gi]),
        .count_o (stat_count[gi])
      );
    end
  endgenerate

  assign hit_count_o  = stat_count[0];
  assign miss_count_o = stat_count[1];
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed testbench for cache_controller with a behavioural cache array
// and a main-memory responder with programmable ack delay.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata_o;
  logic        cpu_ready_o;
  logic [31:0] cache_addr_o;
  logic        cache_hit_i;
  logic [31:0] cache_rdata_i;
  logic        cache_we_o;
  logic [31:0] cache_wdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  logic       sat_inc;
  logic [2:0] sat_count;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cache_controller dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .cpu_req_i     (cpu_req),
    .cpu_we_i      (cpu_we),
    .cpu_addr_i    (cpu_addr),
    .cpu_wdata_i   (cpu_wdata),
    .cpu_rdata_o   (cpu_rdata_o),
    .cpu_ready_o   (cpu_ready_o),
    .cache_addr_o  (cache_addr_o),
    .cache_hit_i   (cache_hit_i),
    .cache_rdata_i (cache_rdata_i),
    .cache_we_o    (cache_we_o),
    .cache_wdata_o (cache_wdata_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdata_i   (mem_rdata_i),
`ifdef CACHE_STATS_EN
    .hit_count_o   (hit_count),
    .miss_count_o  (miss_count),
`endif
    .mem_ack_i     (mem_ack_i)
  );

  // Small counter instance used to exercise saturation quickly.
  cache_stat_counter #(.WIDTH(3)) u_sat (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .inc_i   (sat_inc),
    .count_o (sat_count)
  );

  // Behavioural direct-mapped cache: 64 lines, index addr[7:2], tag addr[31:8].
  logic [31:0] cd [64];
  logic [23:0] ct [64];
  logic        cv [64];
  int          flush_cnt  = 1;
  int          flush_done = 0;

  assign cache_hit_i   = cv[cache_addr_o[7:2]] && (ct[cache_addr_o[7:2]] == cache_addr_o[31:8]);
  assign cache_rdata_i = cd[cache_addr_o[7:2]];

  always @(posedge clk) begin
    if (flush_cnt != flush_done) begin
      for (int i = 0; i < 64; i++) cv[i] <= 1'b0;
      flush_done <= flush_cnt;
    end else if (cache_we_o) begin
      cv[cache_addr_o[7:2]] <= 1'b1;
      ct[cache_addr_o[7:2]] <= cache_addr_o[31:8];
      cd[cache_addr_o[7:2]] <= cache_wdata_o;
    end
  end

  // Main-memory responder: 256 words indexed by mem_addr_o[9:2].
  logic [31:0] mem_arr [256];
  int          ack_delay = 2;
  int          spur_cnt  = 0;

  initial begin
    int wait_cnt;
    int spur_done;
    wait_cnt  = 0;
    spur_done = 0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
    mem_arr[8'd64]  = 32'hDEADBEEF;   // 0x100
    mem_arr[8'd192] = 32'hA5A5A5A5;   // 0x300
    mem_arr[8'd1]   = 32'h44440404;   // 0x404 (wraps to word 1)
    forever begin
      @(posedge clk);
      #1;
      if (mem_ack_i) begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        wait_cnt    = 0;
      end else if (spur_cnt != spur_done) begin
        spur_done   = spur_cnt;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hBAD0BAD0;
      end else if (mem_req_o) begin
        wait_cnt++;
        if (wait_cnt >= ack_delay) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = mem_arr[mem_addr_o[9:2]];
          if (mem_we_o) mem_arr[mem_addr_o[9:2]] = mem_wdata_o;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One CPU access; observes every cycle until cpu_ready_o and checks the
  // result, latency, memory traffic and cache write activity.
  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input int delay,
                      input logic [31:0] exp_rdata, input int exp_lat,
                      input int exp_nreq, input int exp_ncwe,
                      input logic [31:0] exp_cwe, input logic [31:0] exp_maddr);
    logic [31:0] rdata = '0;
    logic [31:0] cwe_data = '0;
    logic [31:0] maddr = '0;
    logic        mwe = 1'b0;
    logic        timeout = 1'b1;
    int          lat = 0;
    int          nreq = 0;
    int          ncwe = 0;
    ack_delay = delay;
    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (cache_we_o) begin
        ncwe++;
        cwe_data = cache_wdata_o;
      end
      if (mem_req_o) begin
        nreq++;
        maddr = mem_addr_o;
        mwe   = mem_we_o;
      end
      if (cpu_ready_o) begin
        rdata   = cpu_rdata_o;
        lat     = c;
        timeout = 1'b0;
        break;
      end
    end
    cpu_req = 1'b0;
    $display("txn %s %s addr=%h wdata=%h rdata=%h lat=%0d mem_cycles=%0d cache_writes=%0d",
             tag, we ? "ST" : "LD", addr, wdata, rdata, lat, nreq, ncwe);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_rdata"}, rdata, exp_rdata);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_mem_cycles"}, 32'(nreq), 32'(exp_nreq));
    chk({tag, "_cache_writes"}, 32'(ncwe), 32'(exp_ncwe));
    if (exp_ncwe > 0) chk({tag, "_cache_wdata"}, cwe_data, exp_cwe);
    if (exp_nreq > 0) begin
      chk({tag, "_mem_addr"}, maddr, exp_maddr);
      chk({tag, "_mem_we"}, 32'(mwe), 32'(we));
    end
  endtask

  initial begin
    logic any_act;
    logic reached;
    rst_ni    = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    sat_inc   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(cpu_ready_o), 32'd0);
    chk("rst_rdata", cpu_rdata_o, 32'd0);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_cache_addr", cache_addr_o, 32'd0);
    chk("rst_sat", 32'(sat_count), 32'd0);
    rst_ni = 1'b1;

    // Sub-word address on a cold cache: memory sees the aligned word.
    xact("ld103", 1'b0, 32'h103, 32'h0, 2, 32'hDEADBEEF, 4, 2, 1, 32'hDEADBEEF, 32'h100);

    // Spurious ack while idle must not move the FSM.
    @(negedge clk);
    spur_cnt++;
    any_act = 1'b0;
    repeat (3) begin
      @(negedge clk);
      any_act |= cpu_ready_o | mem_req_o | cache_we_o;
    end
    $display("txn spur_ack idle activity=%0d", any_act);
    chk("spur_activity", 32'(any_act), 32'd0);
    chk("spur_addr", cache_addr_o, 32'h103);

    flush_cnt++;
    xact("ld100_miss", 1'b0, 32'h100, 32'h0, 2, 32'hDEADBEEF, 4, 2, 1, 32'hDEADBEEF, 32'h100);
    xact("ld100_hit", 1'b0, 32'h100, 32'h0, 2, 32'hDEADBEEF, 2, 0, 0, 32'h0, 32'h0);
    xact("st100_hit", 1'b1, 32'h100, 32'hCAFEF00D, 3, 32'h0, 5, 3, 1, 32'hCAFEF00D, 32'h100);
    chk("st100_mem", mem_arr[8'd64], 32'hCAFEF00D);
    xact("ld100_hit2", 1'b0, 32'h100, 32'h0, 2, 32'hCAFEF00D, 2, 0, 0, 32'h0, 32'h0);
    xact("st204_miss", 1'b1, 32'h204, 32'h12345678, 1, 32'h0, 3, 1, 0, 32'h0, 32'h204);
    chk("st204_mem", mem_arr[8'd129], 32'h12345678);
    xact("ld204_miss", 1'b0, 32'h204, 32'h0, 2, 32'h12345678, 4, 2, 1, 32'h12345678, 32'h204);

    // Reset while a refill is outstanding.
    ack_delay = 50;
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h300;
    reached  = 1'b0;
    for (int c = 0; c < 20 && !reached; c++) begin
      @(negedge clk);
      reached = mem_req_o;
    end
    chk("mr_reached", 32'(reached), 32'd1);
    cpu_req = 1'b0;
    rst_ni  = 1'b0;
    #1;
    $display("txn reset_mid_refill mem_req=%0d cache_we=%0d", mem_req_o, cache_we_o);
    chk("mr_mem_req", 32'(mem_req_o), 32'd0);
    chk("mr_cache_we", 32'(cache_we_o), 32'd0);
    chk("mr_cache_addr", cache_addr_o, 32'd0);
    chk("mr_mem_addr", mem_addr_o, 32'd0);
    any_act = 1'b0;
    repeat (2) begin
      @(negedge clk);
      any_act |= cache_we_o | mem_req_o | cpu_ready_o;
    end
    chk("mr_quiet", 32'(any_act), 32'd0);
    rst_ni = 1'b1;

    // Line 0 must still hold the stored value (no partial refill committed).
    xact("pr_ld100_hit", 1'b0, 32'h100, 32'h0, 2, 32'hCAFEF00D, 2, 0, 0, 32'h0, 32'h0);
    xact("pr_ld300_miss", 1'b0, 32'h300, 32'h0, 1, 32'hA5A5A5A5, 3, 1, 1, 32'hA5A5A5A5, 32'h300);
    xact("pr_ld300_hit", 1'b0, 32'h300, 32'h0, 2, 32'hA5A5A5A5, 2, 0, 0, 32'h0, 32'h0);
    xact("pr_ld300_hit2", 1'b0, 32'h300, 32'h0, 2, 32'hA5A5A5A5, 2, 0, 0, 32'h0, 32'h0);
    xact("pr_ld404_miss", 1'b0, 32'h404, 32'h0, 2, 32'h44440404, 4, 2, 1, 32'h44440404, 32'h404);
    xact("pr_st300_hit", 1'b1, 32'h300, 32'h77778888, 1, 32'h0, 3, 1, 1, 32'h77778888, 32'h300);
`ifdef CACHE_STATS_EN
    chk("stat_hits", hit_count, 32'd3);
    chk("stat_misses", miss_count, 32'd2);
`endif

    // Saturating counter: 5 events, then 6 more into a 3-bit counter.
    @(negedge clk);
    sat_inc = 1'b1;
    repeat (5) @(negedge clk);
    sat_inc = 1'b0;
    $display("txn sat_count after 5 = %0d", sat_count);
    chk("sat_5", 32'(sat_count), 32'd5);
    sat_inc = 1'b1;
    repeat (6) @(negedge clk);
    sat_inc = 1'b0;
    @(negedge clk);
    $display("txn sat_count after 11 = %0d", sat_count);
    chk("sat_max", 32'(sat_count), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
